// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port memory bus arbiter: FSM encoding, port
// indices, counter widths and the port-selection rule.
package mem_arb_pkg;

   localparam logic [1:0] ARB_IDLE  = 2'd0;
   localparam logic [1:0] ARB_ISSUE = 2'd1;
   localparam logic [1:0] ARB_WAIT  = 2'd2;
   localparam logic [1:0] ARB_DONE  = 2'd3;

   localparam logic ARB_PORT_CPU = 1'b0;
   localparam logic ARB_PORT_AUX = 1'b1;

   localparam int WD_CNT_W     = 8;
   localparam int STARVE_CNT_W = 4;

   // The CPU port has fixed priority unless the aux port has lost too often.
   function automatic logic arb_pick_aux(input logic cpu_req, input logic aux_req,
                                         input logic starved);
      return aux_req && (!cpu_req || starved);
   endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of arbitrations lost by the aux port, with a flag that
// marks when the aux port is owed the next grant.
module arb_starve_counter
   import mem_arb_pkg::*;
#(
   parameter int LIMIT = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    inc,
   input  logic                    clr,
   output logic [STARVE_CNT_W-1:0] cnt,
   output logic                    at_limit
);

   localparam logic [STARVE_CNT_W-1:0] LIMIT_CNT = STARVE_CNT_W'(LIMIT);

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != LIMIT_CNT)) begin
         cnt <= cnt + STARVE_CNT_W'(1);
      end
   end

   assign at_limit = (cnt == LIMIT_CNT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises CPU (port 0) and aux (port 1) accesses onto one memory controller
// port, with starvation relief for port 1 and a watchdog on hung accesses.
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    m0_req,
   input  logic [ADDR_WIDTH-1:0]   m0_addr,
   input  logic [DATA_WIDTH-1:0]   m0_wdata,
   input  logic                    m0_is_write,
   output logic                    m0_ack,
   output logic [DATA_WIDTH-1:0]   m0_rdata,
   output logic                    m0_err,
   input  logic                    m1_req,
   input  logic [ADDR_WIDTH-1:0]   m1_addr,
   input  logic [DATA_WIDTH-1:0]   m1_wdata,
   input  logic                    m1_is_write,
   output logic                    m1_ack,
   output logic [DATA_WIDTH-1:0]   m1_rdata,
   output logic                    m1_err,
   output logic                    dev_mem_req,
   output logic [ADDR_WIDTH-1:0]   dev_mem_addr,
   output logic [DATA_WIDTH-1:0]   dev_mem_data_out,
   output logic                    dev_mem_is_write,
   input  logic [DATA_WIDTH-1:0]   dev_mem_data_in,
   input  logic                    dev_mem_busy,
   output logic [1:0]              arb_state,
   output logic [STARVE_CNT_W-1:0] starve_cnt
);

   // Master handshake: req rises with addr/wdata/is_write valid and stays high
   // (inputs stable) until the one-cycle ack; rdata/err are valid with ack.
   // Dropping req early never cancels an access that has already been granted.

   localparam logic [WD_CNT_W-1:0] TIMEOUT_CNT = WD_CNT_W'(TIMEOUT);

   logic [1:0]          state;
   logic                winner;
   logic                err_q;
   logic [WD_CNT_W-1:0] wd_cnt;
   logic [WD_CNT_W-1:0] wd_next;
   logic                arb_fire;
   logic                pick_aux;
   logic                starve_inc;
   logic                starve_clr;
   logic                starved;

   assign arb_fire   = (state == ARB_IDLE) && (m0_req || m1_req) && !dev_mem_busy;
   assign pick_aux   = arb_pick_aux(m0_req, m1_req, starved);
   assign starve_inc = arb_fire && m1_req && !pick_aux;
   assign starve_clr = arb_fire && pick_aux;
   assign wd_next    = wd_cnt + WD_CNT_W'(1);

   arb_starve_counter #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk      (clk),
      .rst      (rst),
      .inc      (starve_inc),
      .clr      (starve_clr),
      .cnt      (starve_cnt),
      .at_limit (starved)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state            <= ARB_IDLE;
         winner           <= ARB_PORT_CPU;
         err_q            <= 1'b0;
         wd_cnt           <= '0;
         dev_mem_addr     <= '0;
         dev_mem_data_out <= '0;
         dev_mem_is_write <= 1'b0;
         m0_rdata         <= '0;
         m1_rdata         <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (arb_fire) begin
                  winner           <= pick_aux ? ARB_PORT_AUX : ARB_PORT_CPU;
                  dev_mem_addr     <= pick_aux ? m1_addr : m0_addr;
                  dev_mem_data_out <= pick_aux ? m1_wdata : m0_wdata;
                  dev_mem_is_write <= pick_aux ? m1_is_write : m0_is_write;
                  state            <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               wd_cnt <= '0;
               state  <= ARB_WAIT;
            end
            ARB_WAIT: begin
               // The incremented count is what both exit conditions look at,
               // so the first WAIT cycle already counts as one.
               wd_cnt <= wd_next;
               if (!dev_mem_busy && (wd_next >= WD_CNT_W'(1))) begin
                  err_q <= 1'b0;
                  if (!dev_mem_is_write) begin
                     if (winner == ARB_PORT_AUX) m1_rdata <= dev_mem_data_in;
                     else                        m0_rdata <= dev_mem_data_in;
                  end
                  state <= ARB_DONE;
               end else if (wd_next == TIMEOUT_CNT) begin
                  err_q <= 1'b1;
                  state <= ARB_DONE;
               end
            end
            ARB_DONE: begin
               state <= ARB_IDLE;
            end
            default: begin
               state <= ARB_IDLE;
            end
         endcase
      end
   end

   assign dev_mem_req = (state == ARB_ISSUE);
   assign m0_ack      = (state == ARB_DONE) && (winner == ARB_PORT_CPU);
   assign m1_ack      = (state == ARB_DONE) && (winner == ARB_PORT_AUX);
   assign m0_err      = m0_ack && err_q;
   assign m1_err      = m1_ack && err_q;
   assign arb_state   = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: memory controller model, transaction-level
// reference model checked every cycle, and literal checks per scenario.
module tb_mem_bus_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int STARVE_LIMIT = 4;
   localparam int TIMEOUT = 255;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m1_req;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic          m0_is_write, m1_is_write;
   logic          m0_ack, m1_ack, m0_err, m1_err;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic          dev_mem_req, dev_mem_is_write, dev_mem_busy;
   logic [AW-1:0] dev_mem_addr;
   logic [DW-1:0] dev_mem_data_out, dev_mem_data_in;
   logic [1:0]    arb_state;
   logic [3:0]    starve_cnt;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   mem_bus_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_is_write(m0_is_write),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_is_write(m1_is_write),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .dev_mem_req(dev_mem_req), .dev_mem_addr(dev_mem_addr),
      .dev_mem_data_out(dev_mem_data_out), .dev_mem_is_write(dev_mem_is_write),
      .dev_mem_data_in(dev_mem_data_in), .dev_mem_busy(dev_mem_busy),
      .arb_state(arb_state), .starve_cnt(starve_cnt)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      total++; bad++;
      $display("FAIL global_timeout: got no finish, required finish before 200us");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // memory controller model: busy rises the cycle after the issue strobe
   int       busy_len = 0;
   int       busy_left = 0;
   logic     req_seen;
   logic [DW-1:0] ctrl_data = '0;
   assign dev_mem_data_in = ctrl_data;

   initial begin
      dev_mem_busy = 1'b0;
      forever begin
         @(negedge clk);
         req_seen = dev_mem_req;
         @(posedge clk);
         #1;
         if (req_seen) busy_left = busy_len;
         if (busy_left > 0) begin
            dev_mem_busy = 1'b1;
            busy_left--;
         end else begin
            dev_mem_busy = 1'b0;
         end
      end
   end

   // reference model and per-cycle compare
   logic          prev_rst = 1'b0;
   logic          prev_m0 = 1'b0, prev_m1 = 1'b0;
   int            model_starve = 0;
   bit            out_busy = 0;
   int            exp_ack_cyc = 0;
   int            last_issue_cyc = 0;
   int            issue_cnt = 0;
   bit            exp_port = 0;
   bit            exp_err = 0;
   bit            exp_w = 0;
   logic [AW-1:0] exp_addr = '0;
   logic [DW-1:0] exp_wdata = '0;
   logic [DW-1:0] model_rd [2];
   bit            ack0_due, ack1_due;

   initial begin
      model_rd[0] = '0;
      model_rd[1] = '0;
      forever begin
         @(negedge clk);
         if (!prev_rst) begin
            out_busy = 0;
            model_starve = 0;
            model_rd[0] = '0;
            model_rd[1] = '0;
            chk("reset_ctrl_outputs",
                {m0_ack, m1_ack, m0_err, m1_err, dev_mem_req, dev_mem_is_write, arb_state, starve_cnt}, '0);
            chk("reset_dev_bus", {dev_mem_addr, dev_mem_data_out}, '0);
            chk("reset_rdata", {m0_rdata, m1_rdata}, '0);
         end else begin
            if (dev_mem_req) begin
               chk("single_outstanding", out_busy, 1'b0);
               issue_cnt++;
               last_issue_cyc = cyc;
               exp_port = prev_m1 && (!prev_m0 || model_starve == STARVE_LIMIT);
               if (exp_port) model_starve = 0;
               else if (prev_m1 && model_starve < STARVE_LIMIT) model_starve++;
               exp_addr  = exp_port ? m1_addr : m0_addr;
               exp_wdata = exp_port ? m1_wdata : m0_wdata;
               exp_w     = exp_port ? m1_is_write : m0_is_write;
               if (busy_len + 1 > TIMEOUT) begin
                  exp_ack_cyc = cyc + 1 + TIMEOUT;
                  exp_err = 1;
               end else begin
                  exp_ack_cyc = cyc + busy_len + 2;
                  exp_err = 0;
               end
               out_busy = 1;
            end
            if (out_busy) begin
               chk("dev_bus_stable", {dev_mem_addr, dev_mem_data_out}, {exp_addr, exp_wdata});
               chk("dev_dir_stable", dev_mem_is_write, exp_w);
            end
            ack0_due = out_busy && (cyc == exp_ack_cyc) && !exp_port;
            ack1_due = out_busy && (cyc == exp_ack_cyc) && exp_port;
            if ((ack0_due || ack1_due) && !exp_w && !exp_err)
               model_rd[exp_port] = ctrl_data;
            chk("m0_ack", m0_ack, ack0_due);
            chk("m1_ack", m1_ack, ack1_due);
            chk("m0_err", m0_err, ack0_due && exp_err);
            chk("m1_err", m1_err, ack1_due && exp_err);
            chk("m0_rdata", m0_rdata, model_rd[0]);
            chk("m1_rdata", m1_rdata, model_rd[1]);
            chk("starve_cnt", starve_cnt, model_starve);
            if (out_busy && cyc >= exp_ack_cyc) out_busy = 0;
         end
         prev_rst = rst;
         prev_m0  = m0_req;
         prev_m1  = m1_req;
      end
   end

   // driver tasks
   task automatic start_req(input int port, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic is_write, output int r);
      @(posedge clk);
      #1;
      if (port == 0) begin
         m0_addr = addr; m0_wdata = wdata; m0_is_write = is_write; m0_req = 1'b1;
      end else begin
         m1_addr = addr; m1_wdata = wdata; m1_is_write = is_write; m1_req = 1'b1;
      end
      r = cyc;
   endtask

   task automatic wait_ack(input int port, output int ack_cyc,
                           output logic [DW-1:0] rd, output logic er);
      bit got = 0;
      ack_cyc = -1;
      rd = '0;
      er = 1'b0;
      for (int i = 0; i < 600 && !got; i++) begin
         @(negedge clk);
         if ((port == 0) ? m0_ack : m1_ack) begin
            got = 1;
            ack_cyc = cyc;
            rd = (port == 0) ? m0_rdata : m1_rdata;
            er = (port == 0) ? m0_err : m1_err;
         end
      end
      chk($sformatf("ack_arrives_p%0d", port), got, 1'b1);
      @(posedge clk);
      #1;
      if (port == 0) m0_req = 1'b0;
      else           m1_req = 1'b0;
   endtask

   task automatic wait_busy_low();
      bit low = 0;
      for (int i = 0; i < 400 && !low; i++) begin
         @(negedge clk);
         if (!dev_mem_busy) low = 1;
      end
      chk("busy_released", low, 1'b1);
   endtask

   // directed scenarios
   int            r, ac, ac0, ac1, ic0;
   logic [DW-1:0] rd;
   logic          er;
   logic [5:0]    seq;
   bit            found, was_m1;

   initial begin
      rst = 1'b0;
      m0_req = 0; m0_addr = '0; m0_wdata = '0; m0_is_write = 0;
      m1_req = 0; m1_addr = '0; m1_wdata = '0; m1_is_write = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("post_reset_idle", arb_state, 2'd0);

      // single read, controller busy 3 cycles
      busy_len = 3;
      ctrl_data = 32'hDEADBEEF;
      ic0 = issue_cnt;
      start_req(0, 32'h100, 32'h0, 1'b0, r);
      wait_ack(0, ac, rd, er);
      chk("t1_issue_cycle", last_issue_cyc, r + 1);
      chk("t1_ack_cycle", ac, r + 6);
      chk("t1_rdata", rd, 32'hDEADBEEF);
      chk("t1_err", er, 1'b0);
      chk("t1_one_issue", issue_cnt - ic0, 1);

      // simultaneous requests
      busy_len = 1;
      ctrl_data = 32'hA5A50001;
      @(posedge clk);
      #1;
      m0_addr = 32'h200; m0_is_write = 0; m0_req = 1;
      m1_addr = 32'h300; m1_is_write = 0; m1_req = 1;
      wait_ack(0, ac0, rd, er);
      chk("t2_m0_rdata", rd, 32'hA5A50001);
      chk("t2_starve_one", starve_cnt, 4'd1);
      ctrl_data = 32'hA5A50002;
      wait_ack(1, ac1, rd, er);
      chk("t2_m1_after_m0", ac1 - ac0, 5);
      chk("t2_m1_rdata", rd, 32'hA5A50002);
      chk("t2_starve_zero", starve_cnt, 4'd0);

      // starvation relief with port 0 requesting continuously
      busy_len = 1;
      ctrl_data = 32'h00003333;
      seq = '0;
      @(posedge clk);
      #1;
      m0_addr = 32'h400; m0_is_write = 0; m0_req = 1;
      m1_addr = 32'h500; m1_is_write = 0; m1_req = 1;
      for (int g = 0; g < 6; g++) begin
         found = 0;
         was_m1 = 0;
         for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
               found = 1;
               was_m1 = m1_ack;
            end
         end
         chk("t3_ack_seen", found, 1'b1);
         seq[g] = was_m1;
         if (was_m1) begin
            @(posedge clk);
            #1 m1_req = 0;
         end
      end
      @(posedge clk);
      #1 m0_req = 0;
      chk("t3_grant_sequence", seq, 6'b010000);
      chk("t3_starve_end", starve_cnt, 4'd0);

      // watchdog timeout, controller busy far longer than TIMEOUT
      busy_len = 300;
      ctrl_data = 32'hBAD0BAD0;
      start_req(0, 32'h600, 32'h0, 1'b0, r);
      wait_ack(0, ac, rd, er);
      chk("t4_timeout_cycles", ac - last_issue_cyc, 256);
      chk("t4_err", er, 1'b1);
      chk("t4_rdata_kept", rd, 32'h00003333);
      wait_busy_low();

      // reset in the middle of WAIT
      busy_len = 100;
      ctrl_data = 32'h5555AAAA;
      start_req(1, 32'h700, 32'h0, 1'b0, r);
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (dev_mem_req) found = 1;
      end
      chk("t5_issued", found, 1'b1);
      repeat (5) @(negedge clk);
      chk("t5_in_wait", arb_state, 2'd2);
      @(posedge clk);
      #1 rst = 1'b0;
      busy_len = 2;
      ctrl_data = 32'h77770005;
      ic0 = issue_cnt;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("t5_state_idle", arb_state, 2'd0);
      chk("t5_rdata_cleared", {m0_rdata, m1_rdata}, 64'h0);
      wait_ack(1, ac, rd, er);
      chk("t5_reissue_rdata", rd, 32'h77770005);
      chk("t5_reissue_err", er, 1'b0);
      chk("t5_one_reissue", issue_cnt - ic0, 1);

      // write from port 1, minimum latency
      busy_len = 0;
      ctrl_data = 32'hFFFF0000;
      start_req(1, 32'h2000, 32'h12345678, 1'b1, r);
      wait_ack(1, ac, rd, er);
      chk("t6_min_latency", ac, r + 3);
      chk("t6_err", er, 1'b0);
      chk("t6_rdata_kept", rd, 32'h77770005);
      chk("t6_dev_addr_data", {dev_mem_addr, dev_mem_data_out}, {32'h2000, 32'h12345678});
      chk("t6_dev_is_write", dev_mem_is_write, 1'b1);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
